mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction/data memory arbiter: data word, RAM status,
// arbiter FSM state and the grant owner used by the optional round-robin mode.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    // A data-side request is pending when either strobe is up; a write wins when both are.
    function automatic logic data_pending(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side request/response signals and the RAM-side strobes/status.
// The arbiter uses the slave modport; the caches plus RAM model use the master modport.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    // instruction cache side
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    // data cache side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a single RAM port between instruction and data caches (IDLE/IACC/DACC FSM).
// Define ARB_RR_EN to alternate grants on contention; otherwise data always wins.
module mem_arbiter
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave cif
);

    arb_state_t state;
    arb_state_t next_state;
    logic       data_req;

`ifdef ARB_RR_EN
    grant_t     last_grant;
    grant_t     next_last_grant;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
`ifdef ARB_RR_EN
            last_grant <= GRANT_INSTR;
`endif
        end else begin
            state      <= next_state;
`ifdef ARB_RR_EN
            last_grant <= next_last_grant;
`endif
        end
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state   = state;
        data_req     = data_pending(cif.dREN, cif.dWEN);
        cif.iwait    = 1'b1;
        cif.iload    = '0;
        cif.dwait    = 1'b1;
        cif.dload    = '0;
        cif.ramREN   = 1'b0;
        cif.ramWEN   = 1'b0;
        cif.ramaddr  = '0;
        cif.ramstore = '0;
`ifdef ARB_RR_EN
        next_last_grant = last_grant;
`endif

        case (state)
            IDLE: begin
                // Grant is only registered here; the RAM is not touched until the next cycle.
                if (data_req && cif.iREN) begin
`ifdef ARB_RR_EN
                    next_state = (last_grant == GRANT_INSTR) ? DACC : IACC;
`else
                    next_state = DACC;
`endif
                end else if (data_req) begin
                    next_state = DACC;
                end else if (cif.iREN) begin
                    next_state = IACC;
                end
            end

            IACC: begin
                if (!cif.iREN) begin
                    next_state = IDLE;
                end else begin
                    cif.ramREN  = 1'b1;
                    cif.ramaddr = cif.iaddr;
                    if (cif.ramstate == ACCESS) begin
                        cif.iwait  = 1'b0;
                        cif.iload  = cif.ramload;
                        next_state = IDLE;
`ifdef ARB_RR_EN
                        next_last_grant = GRANT_INSTR;
`endif
                    end
                end
            end

            DACC: begin
                if (!data_req) begin
                    next_state = IDLE;
                end else begin
                    cif.ramaddr  = cif.daddr;
                    cif.ramstore = cif.dstore;
                    cif.ramWEN   = cif.dWEN;
                    cif.ramREN   = cif.dREN & ~cif.dWEN;
                    if (cif.ramstate == ACCESS) begin
                        cif.dwait  = 1'b0;
                        cif.dload  = cif.dWEN ? '0 : cif.ramload;
                        next_state = IDLE;
`ifdef ARB_RR_EN
                        next_last_grant = GRANT_DATA;
`endif
                    end
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule
